palette_color_mapper: RTL

- Pipelined, parametrised successor to the fixed-colour VGA colour mapper.
- Maps an object index per pixel to 24-bit RGB through a runtime-writable palette, with selectable background modes and per-index blinking.
- Sits between the object/sprite priority logic and the VGA DAC outputs, in the pixel clock domain.
- Output is registered with fixed 2-cycle latency, so the VGA controller must delay hsync/vsync by 2.

---
 rtl/palette_color_mapper.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/palette_color_mapper.sv
// palette_color_mapper
//   Maps a per-pixel object index to 24-bit RGB through a runtime-writable
//   palette. It supports selectable background modes and per-index blinking.
//   There are two register stages, so the latency is fixed at 2 cycles. The VGA
//   controller must delay hsync/vsync by 2 cycles to match.
//
// Ports
//   Clk            pixel clock; all state changes on the rising edge
//   Reset_n        asynchronous active-low reset
//   pix_valid      DrawX/DrawY are in active video
//   frame_start    one-cycle pulse at the start of each frame
//   obj_idx        object index for the current pixel (0 = background)
//   DrawX, DrawY   current pixel coordinates
//   pal_we         palette write strobe (address 0 is read-only)
//   pal_addr       palette write address
//   pal_data       {R,G,B} palette write data
//   bg_mode        0 gradient, 1 solid, 2 checker, 3 black
//   bg_color       {R,G,B} used by the solid and checker modes
//   VGA_R/G/B      registered colour outputs
//   pix_valid_out  pix_valid delayed by 2 cycles
module palette_color_mapper #(
    parameter int                         IDX_W      = 3,
    parameter logic [(1 << IDX_W) - 1:0]  BLINK_MASK = 8'b0001_0000,
    parameter int                         BLINK_LOG2 = 5,
    parameter int                         FRAME_W    = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [IDX_W-1:0]   obj_idx,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               pal_we,
    input  logic [IDX_W-1:0]   pal_addr,
    input  logic [23:0]        pal_data,
    input  logic [1:0]         bg_mode,
    input  logic [23:0]        bg_color,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               pix_valid_out
);

    localparam int NPAL = 1 << IDX_W;

    // Power-on palette contents.
    function automatic logic [23:0] pal_default(input int unsigned idx);
        logic [23:0] c;
        case (idx)
            32'd1:   c = 24'hFF_FF_FF;
            32'd2:   c = 24'hFF_00_00;
            32'd3:   c = 24'h00_FF_00;
            32'd4:   c = 24'hFF_00_FF;
            default: c = 24'h00_00_00;
        endcase
        return c;
    endfunction

    // Horizontal blue-green gradient. DrawX[9:3] is at most 7F, so the
    // subtraction bottoms out at 00 and never wraps.
    function automatic logic [23:0] gradient(input logic [9:0] x);
        logic [7:0] gb;
        gb = 8'h7F - {1'b0, x[9:3]};
        return {8'h3F, gb, gb};
    endfunction

    logic [23:0]        pal_r [0:NPAL-1];
    logic [FRAME_W-1:0] frame_cnt_r;

    // Stage-1 registers
    logic [IDX_W-1:0]   idx_r;
    logic [9:0]         x_r;
    logic [9:0]         y_r;
    logic               valid_r;
    logic [23:0]        pal_rd_r;
    logic               blink_phase_r;
    logic [1:0]         bg_mode_r;
    logic [23:0]        bg_color_r;

    logic [23:0]        bg_s;
    logic [23:0]        color_s;
    logic               unused_s;

    // Only bit 4 of the coordinates selects the checker cell, and bits [9:3]
    // of X drive the gradient.
    assign unused_s = ^{x_r[2:0], y_r[9:5], y_r[3:0]};

    // Palette storage. Entry 0 is the background slot and is never written.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NPAL; i++) begin
                pal_r[i] <= pal_default(i);
            end
        end else if (pal_we && (pal_addr != '0)) begin
            pal_r[pal_addr] <= pal_data;
        end
    end

    // Frame counter. It wraps naturally at 2**FRAME_W.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt_r <= '0;
        end else if (frame_start) begin
            frame_cnt_r <= frame_cnt_r + {{(FRAME_W-1){1'b0}}, 1'b1};
        end
    end

    // Stage 1: capture the pixel, the palette read (old value on a colliding
    // write) and the pre-increment blink phase.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_r         <= '0;
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            valid_r       <= 1'b0;
            pal_rd_r      <= 24'h00_00_00;
            blink_phase_r <= 1'b0;
            bg_mode_r     <= 2'd0;
            bg_color_r    <= 24'h00_00_00;
        end else begin
            idx_r         <= obj_idx;
            x_r           <= DrawX;
            y_r           <= DrawY;
            valid_r       <= pix_valid;
            pal_rd_r      <= pal_r[obj_idx];
            blink_phase_r <= frame_cnt_r[BLINK_LOG2];
            bg_mode_r     <= bg_mode;
            bg_color_r    <= bg_color;
        end
    end

    // Background colour from the stage-1 pixel
    always_comb begin
        bg_s = 24'h00_00_00;
        case (bg_mode_r)
            2'd0: bg_s = gradient(x_r);
            2'd1: bg_s = bg_color_r;
            2'd2: begin
                if (x_r[4] ^ y_r[4]) begin
                    bg_s = bg_color_r;
                end else begin
                    bg_s = gradient(x_r);
                end
            end
            2'd3:    bg_s = 24'h00_00_00;
            default: bg_s = 24'h00_00_00;
        endcase
    end

    // Final colour select: blanking, then background, then blink, then palette.
    always_comb begin
        color_s = 24'h00_00_00;
        if (!valid_r) begin
            color_s = 24'h00_00_00;
        end else if (idx_r == '0) begin
            color_s = bg_s;
        end else if (BLINK_MASK[idx_r] && blink_phase_r) begin
            color_s = bg_s;
        end else begin
            color_s = pal_rd_r;
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R         <= 8'h00;
            VGA_G         <= 8'h00;
            VGA_B         <= 8'h00;
            pix_valid_out <= 1'b0;
        end else begin
            VGA_R         <= color_s[23:16];
            VGA_G         <= color_s[15:8];
            VGA_B         <= color_s[7:0];
            pix_valid_out <= valid_r;
        end
    end

endmodule
